// File: rtl/pkt_deframer.sv
// Serial packet deframer: shifts in bits, hunts for a masked sync pattern, confirms
// frame alignment, then delivers fixed-length packets while tracking sync losses.
module pkt_deframer #(
   parameter int unsigned PKT_W    = 64,
   parameter int unsigned CONFIRM  = 2,
   parameter int unsigned MISS_MAX = 3,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   input  logic [PKT_W-1:0] sync_pat,
   input  logic [PKT_W-1:0] sync_mask,
   output logic [PKT_W-1:0] dout,
   output logic [PKT_W-1:0] pkt_data,
   output logic             pkt_valid,
   output logic             locked,
   output logic             sync_err,
   output logic [CNT_W-1:0] pkt_count
);

   localparam int unsigned BIT_W = $clog2(PKT_W);
   localparam int unsigned HIT_W = 4;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_e;

   state_e             state_q;
   logic [PKT_W-1:0]   shift_q;
   logic [PKT_W-1:0]   shift_d;
   logic [PKT_W-1:0]   pkt_data_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [BIT_W-1:0]   bit_q;
   logic [HIT_W-1:0]   hit_q;
   logic [HIT_W-1:0]   miss_q;
   logic               pkt_valid_q;
   logic               sync_err_q;
   logic               locked_q;

   logic               match_c;
   logic               bound_c;
   logic [HIT_W-1:0]   hit_inc_c;
   logic [HIT_W-1:0]   miss_inc_c;

   // Post-shift value and the frame-boundary / sync-match qualifiers for this cycle
   always_comb begin
      shift_d    = en ? {shift_q[PKT_W-2:0], din} : shift_q;
      match_c    = (((shift_d ^ sync_pat) & sync_mask) == '0);
      bound_c    = (bit_q == BIT_W'(PKT_W - 1));
      hit_inc_c  = hit_q + HIT_W'(1);
      miss_inc_c = miss_q + HIT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= HUNT;
         shift_q     <= '0;
         pkt_data_q  <= '0;
         cnt_q       <= '0;
         bit_q       <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
         pkt_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         pkt_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
         if (en) begin
            shift_q <= shift_d;
            case (state_q)
               HUNT: begin
                  if (match_c) begin
                     bit_q  <= '0;
                     hit_q  <= HIT_W'(1);
                     miss_q <= '0;
                     if (CONFIRM == 1) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end else begin
                        state_q <= CHECK;
                     end
                  end
               end
               CHECK: begin
                  if (!bound_c) begin
                     bit_q <= bit_q + BIT_W'(1);
                  end else begin
                     bit_q <= '0;
                     if (match_c) begin
                        hit_q <= hit_inc_c;
                        // Final confirming frame is itself delivered as the first packet
                        if (hit_inc_c == HIT_W'(CONFIRM)) begin
                           state_q     <= LOCKED;
                           locked_q    <= 1'b1;
                           miss_q      <= '0;
                           pkt_data_q  <= shift_d;
                           pkt_valid_q <= 1'b1;
                           cnt_q       <= cnt_q + CNT_W'(1);
                        end
                     end else begin
                        sync_err_q <= 1'b1;
                        state_q    <= HUNT;
                     end
                  end
               end
               LOCKED: begin
                  if (!bound_c) begin
                     bit_q <= bit_q + BIT_W'(1);
                  end else begin
                     bit_q <= '0;
                     if (match_c) begin
                        miss_q      <= '0;
                        pkt_data_q  <= shift_d;
                        pkt_valid_q <= 1'b1;
                        cnt_q       <= cnt_q + CNT_W'(1);
                     end else begin
                        sync_err_q <= 1'b1;
                        miss_q     <= miss_inc_c;
                        if (miss_inc_c == HIT_W'(MISS_MAX)) begin
                           state_q  <= HUNT;
                           locked_q <= 1'b0;
                        end
                     end
                  end
               end
               default: begin
                  state_q  <= HUNT;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign dout      = shift_q;
   assign pkt_data  = pkt_data_q;
   assign pkt_valid = pkt_valid_q;
   assign sync_err  = sync_err_q;
   assign locked    = locked_q;
   assign pkt_count = cnt_q;

endmodule

// File: tb/tb_pkt_deframer.sv
// Scoreboard bench for pkt_deframer: directed acquisition/loss scenarios plus randomized
// streams, checked against a frame-phase reference model.
module tb_pkt_deframer;

   localparam int unsigned PKT_W    = 64;
   localparam int unsigned CONFIRM  = 2;
   localparam int unsigned MISS_MAX = 3;
   localparam int unsigned CNT_W    = 4;
   localparam logic [PKT_W-1:0] SYNC_DEF = 64'hFF00_0000_0000_0000;

   localparam int S_HUNT  = 0;
   localparam int S_CHECK = 1;
   localparam int S_LOCK  = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en  = 1'b0;
   logic             din = 1'b0;
   logic [PKT_W-1:0] sync_pat  = SYNC_DEF;
   logic [PKT_W-1:0] sync_mask = SYNC_DEF;
   logic [PKT_W-1:0] dout;
   logic [PKT_W-1:0] pkt_data;
   logic             pkt_valid;
   logic             locked;
   logic             sync_err;
   logic [CNT_W-1:0] pkt_count;

   pkt_deframer #(
      .PKT_W(PKT_W), .CONFIRM(CONFIRM), .MISS_MAX(MISS_MAX), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .din(din),
      .sync_pat(sync_pat), .sync_mask(sync_mask),
      .dout(dout), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
      .locked(locked), .sync_err(sync_err), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               cyc;
      bit               is_pkt;
      logic [PKT_W-1:0] data;
      int               count;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  errors   = 0;
   int  err_seen = 0;
   bit  started  = 0;

   // Reference model state: frame phase is tracked as enabled bits since the last alignment
   logic [PKT_W-1:0] m_shift;
   logic [PKT_W-1:0] m_data;
   int m_count, m_state, m_since, m_hits, m_misses;
   int m_cycle = 0;

   task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cycle);
      end
   endtask

   task automatic push_ev(input bit is_pkt);
      ev_t ev;
      ev.cyc    = m_cycle;
      ev.is_pkt = is_pkt;
      ev.data   = m_data;
      ev.count  = m_count;
      exp_q.push_back(ev);
   endtask

   task automatic model_step();
      logic hit;
      m_cycle++;
      if (!rst) begin
         m_shift = '0; m_data = '0; m_count = 0; m_state = S_HUNT;
         m_since = 0; m_hits = 0; m_misses = 0;
         return;
      end
      if (!en) return;
      m_shift = {m_shift[PKT_W-2:0], din};
      hit = (((m_shift ^ sync_pat) & sync_mask) == '0);
      if (m_state == S_HUNT) begin
         if (hit) begin
            m_since = 0; m_hits = 1; m_misses = 0;
            m_state = (CONFIRM == 1) ? S_LOCK : S_CHECK;
         end
         return;
      end
      m_since++;
      if ((m_since % PKT_W) != 0) return;
      if (hit) begin
         if (m_state == S_CHECK) begin
            m_hits++;
            if (m_hits < CONFIRM) return;
            m_state = S_LOCK;
         end
         m_misses = 0;
         m_data   = m_shift;
         m_count  = (m_count + 1) % (1 << CNT_W);
         push_ev(1'b1);
      end else begin
         push_ev(1'b0);
         if (m_state == S_CHECK) m_state = S_HUNT;
         else begin
            m_misses++;
            if (m_misses == MISS_MAX) m_state = S_HUNT;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic d);
      rst = r; en = e; din = d;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [55:0] pl, input bit toggle);
      logic [PKT_W-1:0] fr;
      fr = {hdr, pl};
      for (int i = PKT_W - 1; i >= 0; i--) begin
         cyc(1'b1, 1'b1, fr[i]);
         if (toggle) cyc(1'b1, 1'b0, 1'($urandom));
      end
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1);
   endtask

   // Monitor: per-cycle state compare plus scoreboard pop on every pulse
   always @(negedge clk) begin
      if (started) begin
         ev_t ev;
         chk("dout", dout, m_shift);
         chk("locked", 64'(locked), 64'(m_state == S_LOCK));
         chk("pkt_count", 64'(pkt_count), 64'(m_count));
         chk("pkt_data", pkt_data, m_data);
         if (sync_err) err_seen++;
         if (pkt_valid || sync_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 64'({pkt_valid, sync_err}), 64'd0);
            end else begin
               ev = exp_q.pop_front();
               chk("ev_cycle", 64'(ev.cyc), 64'(m_cycle));
               chk("ev_valid", 64'(pkt_valid), 64'(ev.is_pkt));
               chk("ev_err", 64'(sync_err), 64'(!ev.is_pkt));
               if (ev.is_pkt) begin
                  chk("ev_data", pkt_data, ev.data);
                  chk("ev_count", 64'(pkt_count), 64'(ev.count));
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= m_cycle) begin
            ev = exp_q.pop_front();
            chk("missed_pulse", 64'(0), 64'(1));
         end
      end
   end

   initial begin
      logic [55:0] pl;
      logic [7:0]  hdr;
      logic [PKT_W-1:0] f2;
      int e0, nbits;

      // Reset with en=1, din=1: nothing may shift in
      do_reset(1);
      started = 1;
      do_reset(4);
      chk("rst_dout", dout, 64'd0);
      chk("rst_valid", 64'(pkt_valid), 64'd0);
      chk("rst_locked", 64'(locked), 64'd0);
      chk("rst_count", 64'(pkt_count), 64'd0);

      // Acquire with continuous enable
      send_frame(8'hFF, 56'({$urandom, $urandom}), 1'b0);
      chk("acq_locked_f1", 64'(locked), 64'd0);
      pl = 56'({$urandom, $urandom});
      f2 = {8'hFF, pl};
      send_frame(8'hFF, pl, 1'b0);
      chk("acq_valid_f2", 64'(pkt_valid), 64'd1);
      chk("acq_data_f2", pkt_data, f2);
      chk("acq_locked_f2", 64'(locked), 64'd1);
      send_frame(8'hFF, 56'({$urandom, $urandom}), 1'b0);
      chk("acq_count_f3", 64'(pkt_count), 64'd2);

      // Acquire with en toggling every cycle
      do_reset(2);
      send_frame(8'hFF, 56'({$urandom, $urandom}), 1'b1);
      chk("tog_locked_f1", 64'(locked), 64'd0);
      pl = 56'({$urandom, $urandom});
      f2 = {8'hFF, pl};
      send_frame(8'hFF, pl, 1'b1);
      chk("tog_data_f2", pkt_data, f2);
      chk("tog_locked_f2", 64'(locked), 64'd1);
      send_frame(8'hFF, 56'({$urandom, $urandom}), 1'b1);
      chk("tog_count_f3", 64'(pkt_count), 64'd2);

      // Miss tolerance while locked, then loss of lock
      e0 = err_seen;
      send_frame(8'h00, 56'd0, 1'b0);
      send_frame(8'h00, 56'd0, 1'b0);
      send_frame(8'hFF, 56'd0, 1'b0);
      send_frame(8'h00, 56'd0, 1'b0);
      send_frame(8'h00, 56'd0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("miss_errs", 64'(err_seen - e0), 64'd4);
      chk("miss_locked", 64'(locked), 64'd1);
      chk("miss_count", 64'(pkt_count), 64'd3);
      for (int i = 0; i < 3; i++) send_frame(8'h00, 56'd0, 1'b0);
      chk("loss_locked", 64'(locked), 64'd0);

      // Bad header while confirming
      do_reset(2);
      send_frame(8'hFF, 56'd0, 1'b0);
      e0 = err_seen;
      send_frame(8'h7F, 56'd0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("chk_err", 64'(err_seen - e0), 64'd1);
      chk("chk_locked", 64'(locked), 64'd0);
      chk("chk_count", 64'(pkt_count), 64'd0);

      // Reset mid-packet while locked
      do_reset(2);
      for (int i = 0; i < 6; i++) send_frame(8'hFF, 56'({$urandom, $urandom}), 1'b0);
      chk("pre_rst_count", 64'(pkt_count), 64'd5);
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'($urandom));
      cyc(1'b0, 1'b1, 1'b1);
      chk("mid_rst_locked", 64'(locked), 64'd0);
      chk("mid_rst_count", 64'(pkt_count), 64'd0);
      chk("mid_rst_dout", dout, 64'd0);

      // Counter wrap
      for (int i = 0; i < 18; i++) send_frame(8'hFF, 56'({$urandom, $urandom}), 1'b0);
      chk("wrap_count", 64'(pkt_count), 64'd1);

      // Randomized stream: idle gaps, bad headers, bit slips, mask changes, stray resets
      do_reset(2);
      for (int f = 0; f < 200; f++) begin
         hdr = ($urandom_range(3) != 0) ? 8'hFF : 8'($urandom);
         pl  = 56'({$urandom, $urandom});
         f2  = {hdr, pl};
         if ($urandom_range(19) == 0) sync_mask = '0;
         else if ($urandom_range(7) == 0) sync_mask = SYNC_DEF;
         nbits = ($urandom_range(15) == 0) ? 63 + int'($urandom_range(2)) : 64;
         for (int i = 0; i < nbits; i++) begin
            if ($urandom_range(3) == 0) cyc(1'b1, 1'b0, 1'($urandom));
            if ($urandom_range(999) == 0) cyc(1'b0, 1'($urandom), 1'($urandom));
            cyc(1'b1, 1'b1, (i < 64) ? f2[63 - i] : 1'($urandom));
         end
      end
      sync_mask = SYNC_DEF;

      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
      chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
